// File: rtl/lcd_stream_reader.sv
// lcd_stream_reader
// Consumer side of the framed 17-bit video FIFO. Pops words with a one-cycle
// read latency, checks frame/row framing, strips marker words and presents
// RGB565 pixels with sof/sol/eol/eof tags on a valid/ready interface through
// a 2-entry skid buffer.

module lcd_stream_reader #(
    parameter int FRAME_WIDTH  = 480,
    parameter int FRAME_HEIGHT = 272
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        queue_empty,
    input  logic [16:0] queue_data,
    output logic        queue_rd_en,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_sol,
    output logic        pix_eol,
    output logic        pix_eof,
    output logic        frame_done,
    output logic        fmt_error,
    output logic [2:0]  err_code
);

    localparam int CW = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
    localparam int RW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(FRAME_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);

    localparam logic [16:0] WORD_SOF = 17'h10000;
    localparam logic [16:0] WORD_SOL = 17'h10001;
    localparam logic [16:0] WORD_EOF = 17'h1FFFF;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_NO_SOF   = 3'd1;
    localparam logic [2:0] ERR_NO_SOL   = 3'd2;
    localparam logic [2:0] ERR_IN_ROW   = 3'd3;
    localparam logic [2:0] ERR_NO_EOF   = 3'd4;

    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_WAIT_SOL = 2'd1,
        ST_PIXELS   = 2'd2,
        ST_WAIT_EOF = 2'd3
    } state_t;

    // Buffer entry layout: {eof, eol, sol, sof, data[15:0]}
    localparam int EW = 20;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            en_q;
    logic            inflight_q;
    logic [EW-1:0]   slot0_q, slot0_d;
    logic [EW-1:0]   slot1_q, slot1_d;
    logic            valid0_q, valid0_d;
    logic            valid1_q, valid1_d;
    logic            frame_done_q, frame_done_d;
    logic            fmt_error_q, fmt_error_d;
    logic [2:0]      err_code_q, err_code_d;

    logic [1:0]      occ_s;
    logic            push_s;
    logic            accept_s;
    logic [EW-1:0]   entry_s;
    logic            sof_s, sol_s, eol_s, eof_s;

    // Slots already filled plus the word still in flight bound the pop
    // decision; the downstream ready is deliberately kept out of this path.
    assign occ_s       = {1'b0, valid0_q} + {1'b0, valid1_q} + {1'b0, inflight_q};
    assign queue_rd_en = en_q & ~queue_empty & (occ_s < 2'd2);
    assign accept_s    = valid0_q & pix_ready;

    assign pix_data   = slot0_q[15:0];
    assign pix_sof    = slot0_q[16];
    assign pix_sol    = slot0_q[17];
    assign pix_eol    = slot0_q[18];
    assign pix_eof    = slot0_q[19];
    assign pix_valid  = valid0_q;
    assign frame_done = frame_done_q;
    assign fmt_error  = fmt_error_q;
    assign err_code   = err_code_q;

    // Tags for a pixel word derived from the current row/column position.
    always_comb begin
        sof_s   = (row_q == '0) && (col_q == '0);
        sol_s   = (col_q == '0);
        eol_s   = (col_q == COL_LAST);
        eof_s   = eol_s && (row_q == ROW_LAST);
        entry_s = {eof_s, eol_s, sol_s, sof_s, queue_data[15:0]};
    end

    // Framing FSM: next state, counters and status pulses per sampled word.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        push_s       = 1'b0;
        frame_done_d = 1'b0;
        fmt_error_d  = 1'b0;
        err_code_d   = err_code_q;
        if (inflight_q) begin
            case (state_q)
                ST_WAIT_SOF: begin
                    if (queue_data == WORD_SOF) begin
                        state_d = ST_WAIT_SOL;
                        row_d   = '0;
                    end else begin
                        fmt_error_d = 1'b1;
                        err_code_d  = ERR_NO_SOF;
                    end
                end
                ST_WAIT_SOL: begin
                    if (queue_data == WORD_SOL) begin
                        state_d = ST_PIXELS;
                        col_d   = '0;
                    end else if (queue_data == WORD_SOF) begin
                        row_d       = '0;
                        fmt_error_d = 1'b1;
                        err_code_d  = ERR_NO_SOL;
                    end else begin
                        state_d     = ST_WAIT_SOF;
                        fmt_error_d = 1'b1;
                        err_code_d  = ERR_NO_SOL;
                    end
                end
                ST_PIXELS: begin
                    if (!queue_data[16]) begin
                        push_s = 1'b1;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            if (row_q == ROW_LAST) begin
                                state_d = ST_WAIT_EOF;
                            end else begin
                                row_d   = row_q + RW'(1);
                                state_d = ST_WAIT_SOL;
                            end
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end else if (queue_data == WORD_SOF) begin
                        // Early frame start: resynchronise on it.
                        state_d     = ST_WAIT_SOL;
                        row_d       = '0;
                        fmt_error_d = 1'b1;
                        err_code_d  = ERR_IN_ROW;
                    end else begin
                        state_d     = ST_WAIT_SOF;
                        fmt_error_d = 1'b1;
                        err_code_d  = ERR_IN_ROW;
                    end
                end
                ST_WAIT_EOF: begin
                    if (queue_data == WORD_EOF) begin
                        state_d      = ST_WAIT_SOF;
                        frame_done_d = 1'b1;
                    end else if (queue_data == WORD_SOF) begin
                        state_d     = ST_WAIT_SOL;
                        row_d       = '0;
                        fmt_error_d = 1'b1;
                        err_code_d  = ERR_NO_EOF;
                    end else begin
                        state_d     = ST_WAIT_SOF;
                        fmt_error_d = 1'b1;
                        err_code_d  = ERR_NO_EOF;
                    end
                end
                default: begin
                    state_d = ST_WAIT_SOF;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Skid buffer: slot0 is always the head; slot1 only fills while slot0 is held.
    always_comb begin
        slot0_d  = slot0_q;
        slot1_d  = slot1_q;
        valid0_d = valid0_q;
        valid1_d = valid1_q;
        case ({push_s, accept_s})
            2'b11: begin
                if (valid1_q) begin
                    slot0_d = slot1_q;
                    slot1_d = entry_s;
                end else begin
                    slot0_d = entry_s;
                end
            end
            2'b01: begin
                slot0_d  = slot1_q;
                valid0_d = valid1_q;
                valid1_d = 1'b0;
            end
            2'b10: begin
                if (!valid0_q) begin
                    slot0_d  = entry_s;
                    valid0_d = 1'b1;
                end else begin
                    slot1_d  = entry_s;
                    valid1_d = 1'b1;
                end
            end
            default: begin
                slot0_d = slot0_q;
            end
        endcase
    end

    // State, counters, buffer and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_WAIT_SOF;
            col_q        <= '0;
            row_q        <= '0;
            en_q         <= 1'b0;
            inflight_q   <= 1'b0;
            slot0_q      <= '0;
            slot1_q      <= '0;
            valid0_q     <= 1'b0;
            valid1_q     <= 1'b0;
            frame_done_q <= 1'b0;
            fmt_error_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            en_q         <= 1'b1;
            inflight_q   <= queue_rd_en;
            slot0_q      <= slot0_d;
            slot1_q      <= slot1_d;
            valid0_q     <= valid0_d;
            valid1_q     <= valid1_d;
            frame_done_q <= frame_done_d;
            fmt_error_q  <= fmt_error_d;
            err_code_q   <= err_code_d;
        end
    end

endmodule

// File: tb/tb_lcd_stream_reader.sv
// Directed bench for lcd_stream_reader with a 23x17 frame geometry.

module tb_lcd_stream_reader;

    localparam int W = 23;
    localparam int H = 17;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        queue_empty = 1'b1;
    logic [16:0] queue_data = 17'h0;
    logic        queue_rd_en;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        pix_sof, pix_sol, pix_eol, pix_eof;
    logic        frame_done, fmt_error;
    logic [2:0]  err_code;

    lcd_stream_reader #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .queue_empty (queue_empty),
        .queue_data  (queue_data),
        .queue_rd_en (queue_rd_en),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_sof     (pix_sof),
        .pix_sol     (pix_sol),
        .pix_eol     (pix_eol),
        .pix_eof     (pix_eof),
        .frame_done  (frame_done),
        .fmt_error   (fmt_error),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    // Source FIFO contents and expected/received pixel streams {eof,eol,sol,sof,data}
    logic [16:0] src[$];
    logic [19:0] exp_q[$];
    logic [19:0] got_q[$];

    int  ready_mode = 0;   // 0: always ready, 1: random ~30% ready
    bit  gaps_en = 1'b0;
    int  gap_cnt = 0;

    int  done_cnt = 0;
    int  fe_cnt = 0;
    logic [2:0] last_code = 3'd0;
    int  stall_viol = 0;
    bit  stall_pending = 1'b0;
    logic [20:0] stall_val = 21'h0;

    int  n_checks = 0;
    int  n_errors = 0;
    int  got_idx = 0;
    int  exp_idx = 0;

    // FIFO model with 1-cycle read latency, optional gaps, and ready generation.
    always begin
        @(posedge clk);
        if (queue_rd_en && !queue_empty && src.size() != 0) begin
            queue_data <= src.pop_front();
            gap_cnt = gaps_en ? int'($urandom_range(10, 1)) : 0;
        end else if (gap_cnt != 0) begin
            gap_cnt = gap_cnt - 1;
        end
        #1;
        queue_empty = (src.size() == 0) || (gap_cnt != 0);
        pix_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(99, 0) < 30);
    end

    // Output monitor: records accepted pixels, pulses and stall stability.
    always @(negedge clk) begin
        if (pix_valid && pix_ready) begin
            got_q.push_back({pix_eof, pix_eol, pix_sol, pix_sof, pix_data});
        end
        if (stall_pending && (stall_val != {pix_valid, pix_eof, pix_eol, pix_sol, pix_sof, pix_data})) begin
            stall_viol = stall_viol + 1;
        end
        stall_pending = pix_valid && !pix_ready;
        stall_val = {pix_valid, pix_eof, pix_eol, pix_sol, pix_sof, pix_data};
        if (frame_done) done_cnt = done_cnt + 1;
        if (fmt_error) begin
            fe_cnt = fe_cnt + 1;
            last_code = err_code;
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_rows(input int short_row);
        for (int r = 0; r < H; r++) begin
            int ncol;
            if (short_row >= 0 && r > short_row) break;
            src.push_back(17'h10001);
            ncol = (r == short_row) ? W - 1 : W;
            for (int c = 0; c < ncol; c++) begin
                logic [15:0] px;
                logic eol;
                px = 16'($urandom());
                eol = (c == W - 1);
                src.push_back({1'b0, px});
                exp_q.push_back({eol && (r == H - 1), eol, (c == 0), (r == 0 && c == 0), px});
            end
        end
    endtask

    task automatic push_clean_frame();
        src.push_back(17'h10000);
        push_rows(-1);
        src.push_back(17'h1FFFF);
    endtask

    task automatic wait_idle(input string tag);
        int idle;
        idle = 0;
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            if (src.size() == 0 && !pix_valid && !queue_rd_en) idle++;
            else idle = 0;
            if (idle >= 4) break;
        end
        check(tag, 32'(idle >= 4), 32'd1);
    endtask

    task automatic compare_stream(input string tag);
        int n;
        int ng;
        n  = exp_q.size() - exp_idx;
        ng = got_q.size() - got_idx;
        check({tag, "_count"}, 32'(ng), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < ng) check({tag, "_pix"}, 32'(got_q[got_idx + i]), 32'(exp_q[exp_idx + i]));
        end
        got_idx = got_q.size();
        exp_idx = exp_q.size();
    endtask

    initial begin
        int done_base;
        int fe_base;
        int nsof;
        int neof;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_rd_en", 32'(queue_rd_en), 32'd0);
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_data", 32'(pix_data), 32'd0);
        check("rst_tags", 32'({pix_sof, pix_sol, pix_eol, pix_eof}), 32'd0);
        check("rst_pulses", 32'({frame_done, fmt_error}), 32'd0);
        check("rst_code", 32'(err_code), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1. Clean frame
        done_base = done_cnt; fe_base = fe_cnt;
        push_clean_frame();
        wait_idle("t1_drain");
        nsof = 0; neof = 0;
        for (int i = got_idx; i < got_q.size(); i++) begin
            nsof += int'(got_q[i][16]);
            neof += int'(got_q[i][19]);
        end
        check("t1_sof_count", 32'(nsof), 32'd1);
        check("t1_eof_count", 32'(neof), 32'd1);
        compare_stream("t1");
        check("t1_done", 32'(done_cnt - done_base), 32'd1);
        check("t1_fmt_err", 32'(fe_cnt - fe_base), 32'd0);

        // 2. Backpressure
        done_base = done_cnt; fe_base = fe_cnt;
        ready_mode = 1;
        push_clean_frame();
        wait_idle("t2_drain");
        ready_mode = 0;
        compare_stream("t2");
        check("t2_stall_stable", 32'(stall_viol), 32'd0);
        check("t2_done", 32'(done_cnt - done_base), 32'd1);
        check("t2_fmt_err", 32'(fe_cnt - fe_base), 32'd0);

        // 3. Five frames with FIFO gaps
        done_base = done_cnt; fe_base = fe_cnt;
        gaps_en = 1'b1;
        for (int f = 0; f < 5; f++) push_clean_frame();
        wait_idle("t3_drain");
        gaps_en = 1'b0;
        check("t3_pix_total", 32'(exp_q.size() - exp_idx), 32'd1955);
        compare_stream("t3");
        check("t3_done", 32'(done_cnt - done_base), 32'd5);
        check("t3_fmt_err", 32'(fe_cnt - fe_base), 32'd0);

        // 4. Garbage before sync
        done_base = done_cnt; fe_base = fe_cnt;
        src.push_back(17'h01234);
        src.push_back(17'h1FFFF);
        push_clean_frame();
        wait_idle("t4_drain");
        compare_stream("t4");
        check("t4_fmt_err", 32'(fe_cnt - fe_base), 32'd2);
        check("t4_code", 32'(last_code), 32'd1);
        check("t4_done", 32'(done_cnt - done_base), 32'd1);

        // 5. Short row 5, then a row start
        done_base = done_cnt; fe_base = fe_cnt;
        src.push_back(17'h10000);
        push_rows(5);
        src.push_back(17'h10001);
        wait_idle("t5_drain");
        check("t5_pix_total", 32'(exp_q.size() - exp_idx), 32'd137);
        compare_stream("t5");
        check("t5_fmt_err", 32'(fe_cnt - fe_base), 32'd1);
        check("t5_code", 32'(err_code), 32'd3);
        check("t5_done", 32'(done_cnt - done_base), 32'd0);
        // Still out of sync: pixel and row start are discarded until 10000h
        fe_base = fe_cnt;
        src.push_back(17'h00055);
        src.push_back(17'h10001);
        push_clean_frame();
        wait_idle("t5b_drain");
        compare_stream("t5b");
        check("t5b_fmt_err", 32'(fe_cnt - fe_base), 32'd2);
        check("t5b_code", 32'(err_code), 32'd1);
        check("t5b_done", 32'(done_cnt - done_base), 32'd1);

        // 6. Missing frame end
        done_base = done_cnt; fe_base = fe_cnt;
        src.push_back(17'h10000);
        push_rows(-1);
        push_clean_frame();
        wait_idle("t6_drain");
        compare_stream("t6");
        check("t6_fmt_err", 32'(fe_cnt - fe_base), 32'd1);
        check("t6_code", 32'(err_code), 32'd4);
        check("t6_done", 32'(done_cnt - done_base), 32'd1);

        // 7. Reset mid-row, then a clean frame
        src.push_back(17'h10000);
        push_rows(-1);
        repeat (100) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mr_rd_en", 32'(queue_rd_en), 32'd0);
        check("mr_valid", 32'(pix_valid), 32'd0);
        check("mr_data", 32'(pix_data), 32'd0);
        check("mr_tags", 32'({pix_sof, pix_sol, pix_eol, pix_eof}), 32'd0);
        check("mr_code", 32'(err_code), 32'd0);
        src.delete();
        @(negedge clk);
        reset_n = 1'b1;
        got_idx = got_q.size();
        exp_idx = exp_q.size();
        done_base = done_cnt; fe_base = fe_cnt;
        push_clean_frame();
        wait_idle("mr_drain");
        compare_stream("mr");
        check("mr_done", 32'(done_cnt - done_base), 32'd1);
        check("mr_fmt_err", 32'(fe_cnt - fe_base), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
